// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardwired-zero entry, write bypass and a sequential clear engine.
// Latency: reads are combinational; writes commit at the next rising edge; a clear sweep takes 2**ADDR_W cycles.
// Backpressure: o_wr_ready=0 (and o_busy=1) while a sweep runs; writes offered then are dropped and must be held.
//
// Ports:
//   i_clk       rising-edge clock
//   i_nrst      asynchronous active-low reset; forces a full clear sweep from entry 0
//   i_rd_addr   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data   NUM_RD packed read data, port k at [k*DATA_W +: DATA_W] (combinational)
//   i_wr_en     write request
//   i_wr_addr   write address
//   i_wr_data   write data
//   o_wr_ready  write accepted this cycle (idle only)
//   i_clr_req   single-cycle pulse starting a clear sweep (ignored while one runs)
//   o_busy      clear sweep in progress
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_clr_req,
  output logic                     o_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_acc;
  logic                w_wr_store;
  logic                w_wr_to_zero;

  // Status flags decode the state register only, so there is no combinational path from inputs.
  assign o_busy     = (r_state == ST_CLEAR);
  assign o_wr_ready = (r_state == ST_IDLE);

  assign w_wr_acc     = i_wr_en & o_wr_ready;
  assign w_wr_to_zero = (ZERO_REG != 0) && (i_wr_addr == '0);
  // Writes to the hardwired-zero entry are accepted upstream but never stored.
  assign w_wr_store   = w_wr_acc & ~w_wr_to_zero;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        // Pointer wraps back to 0 on the last entry; i_clr_req is deliberately not looked at here.
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (&r_clr_ptr) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage has no reset so it can map to latch/RAM macros; the sweep is the only initialiser.
  // Sweep writes and accepted writes are mutually exclusive because writes are accepted only in idle.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_store) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_ra_zero;
    logic              w_ra_byp;

    assign w_ra      = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_ra_byp  = (BYPASS != 0) && w_wr_acc && (i_wr_addr == w_ra);

    // Priority: sweep/reset, zero entry, bypass, array. Forcing 0 during the sweep keeps
    // never-initialised storage from leaking X before the first sweep completes.
    assign o_rd_data[k*DATA_W +: DATA_W] =
        (r_state == ST_CLEAR) ? '0 :
        w_ra_zero             ? '0 :
        w_ra_byp              ? i_wr_data :
                                r_mem[w_ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  // Three configurations share one stimulus stream; addresses and data are truncated per DUT.
  //  A: 32b x 32, 4 read ports, zero reg, bypass
  //  B: 16b x 8,  2 read ports, zero reg, no bypass
  //  C: 32b x 32, 1 read port,  no zero reg, bypass
  logic        clk;
  logic        nrst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic [4:0]  ra [4];

  logic [19:0]  a_rd_addr;
  logic [127:0] a_rd_data;
  logic [5:0]   b_rd_addr;
  logic [31:0]  b_rd_data;
  logic [4:0]   c_rd_addr;
  logic [31:0]  c_rd_data;
  logic [2:0]   busy_o;
  logic [2:0]   rdy_o;

  int n_cmp;
  int n_err;

  // Reference model state
  int          depth    [3];
  int          nrd      [3];
  bit          zr       [3];
  bit          bp       [3];
  logic [31:0] dmask    [3];
  logic [4:0]  amask    [3];
  int          busy_left[3];
  logic [31:0] mem      [3][32];
  string       nm       [3];

  assign a_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
  assign b_rd_addr = {ra[1][2:0], ra[0][2:0]};
  assign c_rd_addr = ra[0];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .i_clk(clk), .i_nrst(nrst), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(rdy_o[0]), .i_clr_req(clr_req), .o_busy(busy_o[0]));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .i_clk(clk), .i_nrst(nrst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr[2:0]), .i_wr_data(wr_data[15:0]),
    .o_wr_ready(rdy_o[1]), .i_clr_req(clr_req), .o_busy(busy_o[1]));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0), .BYPASS(1)) u_c (
    .i_clk(clk), .i_nrst(nrst), .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(rdy_o[2]), .i_clr_req(clr_req), .o_busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_rd(int d, int k);
    case (d)
      0:       return a_rd_data[k*32 +: 32];
      1:       return {16'h0, b_rd_data[k*16 +: 16]};
      default: return c_rd_data;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(int d, int k);
    logic [4:0]  a;
    logic [4:0]  wa;
    a  = ra[k] & amask[d];
    wa = wr_addr & amask[d];
    if (busy_left[d] > 0)                 return 32'h0;
    if (zr[d] && a == 5'd0)               return 32'h0;
    if (bp[d] && wr_en && wa == a)        return wr_data & dmask[d];
    return mem[d][a];
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.busy", nm[d]), {31'h0, busy_o[d]}, (busy_left[d] > 0) ? 32'h1 : 32'h0);
      chk($sformatf("%s.wr_ready", nm[d]), {31'h0, rdy_o[d]}, (busy_left[d] > 0) ? 32'h0 : 32'h1);
      for (int k = 0; k < nrd[d]; k++)
        chk($sformatf("%s.rd%0d[a=%0d]", nm[d], k, ra[k] & amask[d]), dut_rd(d, k), exp_rd(d, k));
    end
  endtask

  // Behaviour at a clock edge: a sweep simply counts down and leaves the whole file zero,
  // since nothing is observable or writable while it runs.
  task automatic model_edge();
    logic [4:0] wa;
    for (int d = 0; d < 3; d++) begin
      if (!nrst) continue;
      if (busy_left[d] > 0) begin
        busy_left[d]--;
        if (busy_left[d] == 0)
          for (int e = 0; e < 32; e++) mem[d][e] = 32'h0;
      end else begin
        wa = wr_addr & amask[d];
        if (wr_en && !(zr[d] && wa == 5'd0)) mem[d][wa] = wr_data & dmask[d];
        if (clr_req) busy_left[d] = depth[d];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    nrst = 1'b0;
    for (int d = 0; d < 3; d++) busy_left[d] = depth[d];
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
  endtask

  task automatic read_all();
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'(a + k);
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    depth = '{32, 8, 32};
    nrd   = '{4, 2, 1};
    zr    = '{1'b1, 1'b1, 1'b0};
    bp    = '{1'b1, 1'b0, 1'b1};
    dmask = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    amask = '{5'h1F, 5'h07, 5'h1F};
    nm    = '{"A", "B", "C"};
    for (int d = 0; d < 3; d++)
      for (int e = 0; e < 32; e++) mem[d][e] = 32'h0;
    wr_addr = '0; wr_data = '0;
    for (int k = 0; k < 4; k++) ra[k] = 5'(k);
    idle_inputs();
    assert_reset();
    #1;

    // Reset held, then release: sweep length and all-zero contents
    repeat (3) tick();
    nrst = 1'b1;
    repeat (36) tick();
    read_all();

    // Write then read on two ports
    do_write(5'd5, 32'hDEAD_BEEF); tick();
    idle_inputs(); ra[0] = 5'd5; ra[1] = 5'd5; tick();

    // Same-cycle bypass (A, C) vs old value (B)
    do_write(5'd7, 32'h0000_1234); ra[0] = 5'd7; tick();
    idle_inputs(); tick();

    // Writes to entry 0
    do_write(5'd0, 32'hFFFF_FFFF); ra[0] = 5'd0; ra[1] = 5'd0; tick();
    idle_inputs(); tick();

    // Fill, clear with a concurrent write, second request mid-sweep ignored
    for (int a = 1; a < 32; a++) begin
      do_write(5'(a), $urandom); ra[0] = 5'(a); ra[1] = 5'(a - 1); tick();
    end
    do_write(5'd3, 32'h0000_00AA); clr_req = 1'b1; ra[0] = 5'd3; tick();
    idle_inputs();
    for (int c = 1; c < 36; c++) begin
      clr_req = (c == 10);
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom);
      tick();
    end
    read_all();

    // Held write across a sweep lands once ready returns
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    do_write(5'd9, 32'h5A5A_C3C3); ra[0] = 5'd9; ra[1] = 5'd1;
    repeat (34) tick();
    idle_inputs(); tick();

    // Reset in the middle of a sweep restarts it in full
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (11) tick();
    do_write(5'd12, 32'h1111_2222);
    assert_reset(); tick(); tick();
    nrst = 1'b1;
    idle_inputs();
    repeat (34) tick();
    read_all();

    // Randomised traffic with occasional clear requests and resets
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      clr_req = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        assert_reset(); tick();
        nrst = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
